// File: rtl/tmr_voter_ctrl.sv
// Triple-modular-redundancy voter with per-copy fault tracking.
// The voter starts in TMR mode. It retires a copy that keeps disagreeing and
// then falls back to comparing the two remaining healthy copies (SIMPLEX).
// If that pair also keeps disagreeing, it ends in FAIL, which only clr_fault
// or reset can leave. data_out is combinational; all status outputs are registered.
module tmr_voter_ctrl #(
   parameter int WIDTH          = 8,
   parameter int MISMATCH_LIMIT = 3,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic [WIDTH-1:0] data_c,
   input  logic             inj_a,
   input  logic             inj_b,
   input  logic             inj_c,
   input  logic             clr_fault,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       mode,
   output logic [2:0]       fault_vec,
   output logic             tmr_error,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int            CW      = $clog2(MISMATCH_LIMIT + 1);
   localparam logic [CW-1:0] LIM     = CW'(MISMATCH_LIMIT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      ST_TMR     = 2'b00,
      ST_SIMPLEX = 2'b01,
      ST_FAIL    = 2'b10
   } state_t;

   state_t             state_r;
   logic [2:0]         fault_vec_r;
   logic               tmr_error_r;
   logic [CNT_W-1:0]   err_cnt_r;
   logic [CW-1:0]      cnt_a_r, cnt_b_r, cnt_c_r, pair_cnt_r;

   logic [WIDTH-1:0]   x_a_s, x_b_s, x_c_s, maj_s, h1_s, h2_s;
   logic               dis_a_s, dis_b_s, dis_c_s, pair_dis_s;
   logic               any_dis_s, multi_dis_s, disagree_s;
   logic [CW-1:0]      cnt_a_nxt_s, cnt_b_nxt_s, cnt_c_nxt_s, pair_cnt_nxt_s;
   logic               hit_a_s, hit_b_s, hit_c_s, any_hit_s, multi_hit_s, pair_hit_s;

   // Counter step that stops at the limit so a held count cannot wrap.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == LIM) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   // Majority vote, per-copy disagreement, healthy-pair selection and output mux.
   always_comb begin
      x_a_s       = inj_a ? ~data_a : data_a;
      x_b_s       = inj_b ? ~data_b : data_b;
      x_c_s       = inj_c ? ~data_c : data_c;
      maj_s       = (x_a_s & x_b_s) | (x_a_s & x_c_s) | (x_b_s & x_c_s);
      dis_a_s     = |(x_a_s ^ maj_s);
      dis_b_s     = |(x_b_s ^ maj_s);
      dis_c_s     = |(x_c_s ^ maj_s);
      any_dis_s   = dis_a_s | dis_b_s | dis_c_s;
      multi_dis_s = (dis_a_s & dis_b_s) | (dis_a_s & dis_c_s) | (dis_b_s & dis_c_s);

      // The two healthy copies, taken in A,B,C order.
      case (fault_vec_r)
         3'b001:  begin h1_s = x_b_s; h2_s = x_c_s; end
         3'b010:  begin h1_s = x_a_s; h2_s = x_c_s; end
         3'b100:  begin h1_s = x_a_s; h2_s = x_b_s; end
         default: begin h1_s = x_a_s; h2_s = x_b_s; end
      endcase
      pair_dis_s = (h1_s != h2_s);

      cnt_a_nxt_s    = dis_a_s    ? sat_inc(cnt_a_r)    : '0;
      cnt_b_nxt_s    = dis_b_s    ? sat_inc(cnt_b_r)    : '0;
      cnt_c_nxt_s    = dis_c_s    ? sat_inc(cnt_c_r)    : '0;
      pair_cnt_nxt_s = pair_dis_s ? sat_inc(pair_cnt_r) : '0;
      hit_a_s        = (cnt_a_nxt_s == LIM);
      hit_b_s        = (cnt_b_nxt_s == LIM);
      hit_c_s        = (cnt_c_nxt_s == LIM);
      pair_hit_s     = (pair_cnt_nxt_s == LIM);
      any_hit_s      = hit_a_s | hit_b_s | hit_c_s;
      multi_hit_s    = (hit_a_s & hit_b_s) | (hit_a_s & hit_c_s) | (hit_b_s & hit_c_s);

      case (state_r)
         ST_TMR:     begin data_out = maj_s; disagree_s = any_dis_s;  end
         ST_SIMPLEX: begin data_out = h1_s;  disagree_s = pair_dis_s; end
         ST_FAIL:    begin data_out = maj_s; disagree_s = any_dis_s;  end
         default:    begin data_out = maj_s; disagree_s = any_dis_s;  end
      endcase
   end

   // Mode FSM with fault flags, mismatch counters, error flag and error counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_TMR;
         fault_vec_r <= 3'b000;
         tmr_error_r <= 1'b0;
         err_cnt_r   <= '0;
         cnt_a_r     <= '0;
         cnt_b_r     <= '0;
         cnt_c_r     <= '0;
         pair_cnt_r  <= '0;
      end else if (clr_fault) begin
         state_r     <= ST_TMR;
         fault_vec_r <= 3'b000;
         tmr_error_r <= 1'b0;
         err_cnt_r   <= '0;
         cnt_a_r     <= '0;
         cnt_b_r     <= '0;
         cnt_c_r     <= '0;
         pair_cnt_r  <= '0;
      end else begin
         if (disagree_s && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CNT_W'(1);
         end else begin
            err_cnt_r <= err_cnt_r;
         end
         case (state_r)
            ST_TMR: begin
               tmr_error_r <= multi_dis_s;
               pair_cnt_r  <= '0;
               if (any_hit_s) begin
                  // Retire the copies that hit the limit and restart the copy counters.
                  fault_vec_r <= fault_vec_r | {hit_c_s, hit_b_s, hit_a_s};
                  state_r     <= multi_hit_s ? ST_FAIL : ST_SIMPLEX;
                  cnt_a_r     <= '0;
                  cnt_b_r     <= '0;
                  cnt_c_r     <= '0;
               end else begin
                  cnt_a_r     <= cnt_a_nxt_s;
                  cnt_b_r     <= cnt_b_nxt_s;
                  cnt_c_r     <= cnt_c_nxt_s;
               end
            end
            ST_SIMPLEX: begin
               tmr_error_r <= pair_dis_s;
               if (pair_hit_s) begin
                  state_r    <= ST_FAIL;
                  pair_cnt_r <= '0;
               end else begin
                  pair_cnt_r <= pair_cnt_nxt_s;
               end
            end
            ST_FAIL: begin
               tmr_error_r <= 1'b1;
            end
            default: begin
               state_r     <= ST_TMR;
               tmr_error_r <= 1'b0;
            end
         endcase
      end
   end

   assign mode      = state_r;
   assign fault_vec = fault_vec_r;
   assign tmr_error = tmr_error_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_tmr_voter_ctrl.sv
// Directed bench for tmr_voter_ctrl. Each step records the expected post-edge
// status in a scoreboard queue. After the edge, the step pops that entry and
// compares it with the DUT. data_out is checked before the edge because the
// design drives it combinationally. err_cnt is narrowed to 3 bits so that
// saturation can be reached.
module tb_tmr_voter_ctrl;

   localparam int W  = 8;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic [W-1:0]  data_a, data_b, data_c;
   logic          inj_a, inj_b, inj_c, clr_fault;
   logic [W-1:0]  data_out;
   logic [1:0]    mode;
   logic [2:0]    fault_vec;
   logic          tmr_error;
   logic [CW-1:0] err_cnt;

   typedef struct {
      string         tag;
      logic [1:0]    mode;
      logic [2:0]    fault;
      logic          terr;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   tmr_voter_ctrl #(.WIDTH(W), .MISMATCH_LIMIT(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .data_a(data_a), .data_b(data_b), .data_c(data_c),
      .inj_a(inj_a), .inj_b(inj_b), .inj_c(inj_c),
      .clr_fault(clr_fault),
      .data_out(data_out), .mode(mode), .fault_vec(fault_vec),
      .tmr_error(tmr_error), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic ia, input logic ib, input logic ic, input logic clr,
                       input logic [W-1:0] exp_out, input logic [1:0] exp_mode,
                       input logic [2:0] exp_fault, input logic exp_terr,
                       input logic [CW-1:0] exp_cnt, input string tag);
      exp_t e;
      @(negedge clk);
      data_a = a; data_b = b; data_c = c;
      inj_a = ia; inj_b = ib; inj_c = ic; clr_fault = clr;
      #1;
      chk($sformatf("%s/data_out", tag), 32'(data_out), 32'(exp_out));
      e.tag = tag; e.mode = exp_mode; e.fault = exp_fault; e.terr = exp_terr; e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk($sformatf("%s/sb_level", tag), 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk($sformatf("%s/mode", e.tag),      32'(mode),      32'(e.mode));
         chk($sformatf("%s/fault_vec", e.tag), 32'(fault_vec), 32'(e.fault));
         chk($sformatf("%s/tmr_error", e.tag), 32'(tmr_error), 32'(e.terr));
         chk($sformatf("%s/err_cnt", e.tag),   32'(err_cnt),   32'(e.cnt));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk($sformatf("%s/mode", tag),      32'(mode),      32'd0);
      chk($sformatf("%s/fault_vec", tag), 32'(fault_vec), 32'd0);
      chk($sformatf("%s/tmr_error", tag), 32'(tmr_error), 32'd0);
      chk($sformatf("%s/err_cnt", tag),   32'(err_cnt),   32'd0);
   endtask

   initial begin
      rst = 1'b0;
      data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
      inj_a = 1'b0; inj_b = 1'b0; inj_c = 1'b0; clr_fault = 1'b0;
      #3;
      chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: clean agreement
      for (int i = 0; i < 20; i++)
         step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd0, "s1_clean");

      // 2: transient disagreement on B for two cycles
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd1, "s2_tr1");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd2, "s2_tr2");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd2, "s2_quiet");

      // 3: B held faulty and retired on the third edge
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd3, "s3_b1");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd4, "s3_b2");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b01, 3'b010, 1'b0, 3'd5, "s3_b3");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b01, 3'b010, 1'b0, 3'd5, "s3_b_ignored");
      // SIMPLEX drives x_a even though the majority would give 5A
      step(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 2'b01, 3'b010, 1'b1, 3'd6, "s3_sel_a");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b01, 3'b010, 1'b0, 3'd6, "s3_pair_ok");

      // 4: the healthy pair disagrees; err_cnt saturates at 7
      step(8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 3'b010, 1'b1, 3'd7, "s4_p1");
      step(8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 3'b010, 1'b1, 3'd7, "s4_p2");
      step(8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 3'b010, 1'b1, 3'd7, "s4_p3");
      step(8'h00, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b10, 3'b010, 1'b1, 3'd7, "s4_fail_maj");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b10, 3'b010, 1'b1, 3'd7, "s4_fail_hold");

      // 5: clr_fault leaves FAIL
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd0, "s5_clr");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd0, "s5_after");

      // Two copies reach the limit together: direct to FAIL with both flags set
      step(8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000, 1'b1, 3'd1, "dual1");
      step(8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 3'b000, 1'b1, 3'd2, "dual2");
      step(8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b10, 3'b011, 1'b1, 3'd3, "dual3");
      step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 3'b000, 1'b0, 3'd0, "dual_clr");

      // 6: retire C, then apply asynchronous reset between edges
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd1, "s6_c1");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd2, "s6_c2");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 2'b01, 3'b100, 1'b0, 3'd3, "s6_c3");
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 2'b01, 3'b100, 1'b1, 3'd4, "s6_pair");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_vals("s6_async_rst");
      @(negedge clk);
      rst = 1'b1;
      inj_b = 1'b0; inj_c = 1'b0;
      for (int i = 0; i < 4; i++)
         step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 3'b000, 1'b0, 3'd0, "s6_post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
